// File: rtl/fetch_decode_buffer.sv
// Two-entry skid buffer between fetch and decode. Each entry holds {instr, pc+4};
// the head entry is decoded into MIPS-style fields, and NOP_INSTR is presented when empty.
module fetch_decode_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h00000000,
  parameter int          PC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [31:0]         instr_in,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic                in_ready,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] pc_plus4_out,
  output logic [5:0]          opcode_out,
  output logic [4:0]          rs_out,
  output logic [4:0]          rt_out,
  output logic [4:0]          rd_out,
  output logic [15:0]         imm16_out,
  output logic [1:0]          count
);

  logic [31:0]         r_instr [2];
  logic [PC_WIDTH-1:0] r_pc4   [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_count_nxt;

  // Handshakes depend only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign count     = r_count;

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_instr[0] <= '0;
      r_instr[1] <= '0;
      r_pc4[0]   <= '0;
      r_pc4[1]   <= '0;
    end else if (flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= instr_in;
        r_pc4[r_wr_ptr]   <= pc_in + PC_WIDTH'(4);
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
    end
  end

  assign instr_out    = out_valid ? r_instr[r_rd_ptr] : NOP_INSTR;
  assign pc_plus4_out = out_valid ? r_pc4[r_rd_ptr] : '0;
  assign opcode_out   = instr_out[31:26];
  assign rs_out       = instr_out[25:21];
  assign rt_out       = instr_out[20:16];
  assign rd_out       = instr_out[15:11];
  assign imm16_out    = instr_out[15:0];

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed scenarios plus a randomized
// run scored against a queue-based model of the two-entry FIFO.
module tb_fetch_decode_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4_out;
  logic [5:0]  opcode_out;
  logic [4:0]  rs_out;
  logic [4:0]  rt_out;
  logic [4:0]  rd_out;
  logic [15:0] imm16_out;
  logic [1:0]  count;

  int n_vec;
  int n_err;

  // Model: each element is {instr, pc+4}; front is the head.
  logic [63:0] model_q [$];

  fetch_decode_buffer #(.NOP_INSTR(32'h00000000), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr_in(instr_in), .pc_in(pc_in),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .pc_plus4_out(pc_plus4_out), .opcode_out(opcode_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .imm16_out(imm16_out),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock: update the model from the inputs currently applied, then
  // let the DUT take the edge and settle.
  task automatic tick();
    bit do_pop;
    bit do_push;
    if (flush) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && out_ready;
      do_push = in_valid && (model_q.size() < 2);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({instr_in, pc_in + 32'd4});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    instr_in  = 32'h0;
    pc_in     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_vec++;
    if (count !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: count=%0d in_ready=%b out_valid=%b, want 0/1/0", count, in_ready, out_valid);
    end
    n_vec++;
    if (instr_out !== 32'h0 || pc_plus4_out !== 32'h0 || opcode_out !== 6'h0 || imm16_out !== 16'h0) begin
      n_err++;
      $display("FAIL reset_data: instr=%h pc4=%h op=%h imm=%h, want all 0", instr_out, pc_plus4_out, opcode_out, imm16_out);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    model_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_pass();
    idle_inputs();
    in_valid = 1'b1; instr_in = 32'h2008FFFF; pc_in = 32'h00400000; out_ready = 1'b1;
    n_vec++;
    if (out_valid !== 1'b0 || instr_out !== 32'h0) begin
      n_err++;
      $display("FAIL single_no_bypass: out_valid=%b instr=%h, want 0/00000000", out_valid, instr_out);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || pc_plus4_out !== 32'h00400004 || instr_out !== 32'h2008FFFF) begin
      n_err++;
      $display("FAIL single_head: out_valid=%b pc4=%h instr=%h, want 1/00400004/2008ffff", out_valid, pc_plus4_out, instr_out);
    end
    n_vec++;
    if (opcode_out !== 6'h08 || rs_out !== 5'd0 || rt_out !== 5'd8 || rd_out !== 5'd31 || imm16_out !== 16'hFFFF) begin
      n_err++;
      $display("FAIL single_fields: op=%h rs=%0d rt=%0d rd=%0d imm=%h, want 08/0/8/31/ffff", opcode_out, rs_out, rt_out, rd_out, imm16_out);
    end
    tick();
    n_vec++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_popped: count=%0d out_valid=%b, want 0/0", count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    in_valid = 1'b1; instr_in = 32'hAAAA0001; pc_in = 32'h00001000;
    tick();
    instr_in = 32'hBBBB0002; pc_in = 32'h00001004;
    tick();
    instr_in = 32'hCCCC0003; pc_in = 32'h00001008;
    n_vec++;
    if (count !== 2'd2 || in_ready !== 1'b0 || instr_out !== 32'hAAAA0001) begin
      n_err++;
      $display("FAIL bp_full: count=%0d in_ready=%b instr=%h, want 2/0/aaaa0001", count, in_ready, instr_out);
    end
    repeat (3) tick();
    n_vec++;
    if (count !== 2'd2 || instr_out !== 32'hAAAA0001 || pc_plus4_out !== 32'h00001004) begin
      n_err++;
      $display("FAIL bp_hold: count=%0d instr=%h pc4=%h, want 2/aaaa0001/00001004", count, instr_out, pc_plus4_out);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++;
    if (count !== 2'd1 || instr_out !== 32'hBBBB0002 || pc_plus4_out !== 32'h00001008) begin
      n_err++;
      $display("FAIL bp_second: count=%0d instr=%h pc4=%h, want 1/bbbb0002/00001008", count, instr_out, pc_plus4_out);
    end
    tick();
    n_vec++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drained: count=%0d out_valid=%b, want 0/0 (full-time input must be dropped)", count, out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] prev;
    idle_inputs();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      instr_in = 32'h10000000 + i;
      pc_in    = 32'h00008000 + 32'(i * 4);
      prev     = instr_in;
      tick();
      n_vec++;
      if (count !== 2'd1 || in_ready !== 1'b1 || instr_out !== prev) begin
        n_err++;
        $display("FAIL stream_%0d: count=%0d in_ready=%b instr=%h, want 1/1/%h", i, count, in_ready, instr_out, prev);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1'b1; instr_in = 32'h11111111; pc_in = 32'h100;
    tick();
    instr_in = 32'h22222222; pc_in = 32'h104;
    tick();
    flush = 1'b1; out_ready = 1'b1; instr_in = 32'h33333333; pc_in = 32'h108;
    tick();
    flush = 1'b0;
    n_vec++;
    if (count !== 2'd0 || out_valid !== 1'b0 || instr_out !== 32'h0 || pc_plus4_out !== 32'h0) begin
      n_err++;
      $display("FAIL flush_empty: count=%0d out_valid=%b instr=%h pc4=%h, want 0/0/0/0", count, out_valid, instr_out, pc_plus4_out);
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (count !== 2'd0) begin
      n_err++;
      $display("FAIL flush_dropped: count=%0d, want 0", count);
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    in_valid = 1'b1; instr_in = 32'h8C220004; pc_in = 32'hFFFFFFFC;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || pc_plus4_out !== 32'h00000000 || instr_out !== 32'h8C220004) begin
      n_err++;
      $display("FAIL wrap_pc4: out_valid=%b pc4=%h instr=%h, want 1/00000000/8c220004", out_valid, pc_plus4_out, instr_out);
    end
    drain();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    in_valid = 1'b1; instr_in = 32'h44444444; pc_in = 32'h200;
    tick();
    instr_in = 32'h55555555;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst: count=%0d out_valid=%b in_ready=%b instr=%h, want 0/0/1/0", count, out_valid, in_ready, instr_out);
    end
    #1 rst = 1'b0;
    model_q.delete();
    @(posedge clk);
    #1;
    in_valid = 1'b1; instr_in = 32'h66666666; pc_in = 32'h300;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (count !== 2'd1 || instr_out !== 32'h66666666 || pc_plus4_out !== 32'h304) begin
      n_err++;
      $display("FAIL post_rst_push: count=%0d instr=%h pc4=%h, want 1/66666666/00000304", count, instr_out, pc_plus4_out);
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [1:0]  e_count;
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 6);
      instr_in  = $urandom;
      pc_in     = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      if ($urandom_range(0, 19) == 0) pc_in = 32'hFFFFFFFC;
      e_count = 2'(model_q.size());
      if (model_q.size() != 0) begin
        e_instr = model_q[0][63:32];
        e_pc4   = model_q[0][31:0];
      end else begin
        e_instr = 32'h00000000;
        e_pc4   = 32'h0;
      end
      n_vec++;
      if (count !== e_count || in_ready !== (e_count < 2'd2) || out_valid !== (e_count != 2'd0)) begin
        n_err++;
        $display("FAIL rand_ctrl_%0d: count=%0d in_ready=%b out_valid=%b, want count=%0d", i, count, in_ready, out_valid, e_count);
      end
      n_vec++;
      if (instr_out !== e_instr || pc_plus4_out !== e_pc4 || opcode_out !== e_instr[31:26] ||
          rs_out !== e_instr[25:21] || rt_out !== e_instr[20:16] || rd_out !== e_instr[15:11] ||
          imm16_out !== e_instr[15:0]) begin
        n_err++;
        $display("FAIL rand_data_%0d: instr=%h pc4=%h, want %h/%h", i, instr_out, pc_plus4_out, e_instr, e_pc4);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_single_pass();
    test_backpressure();
    test_streaming();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000000; the instruction word presented on instr_out whenever the buffer is empty.
REQ-002 Parameter PC_WIDTH, default 32; the width of pc_in and pc_plus4_out.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  fetch stage presents a valid instruction.
REQ-006 instr_in  input  32  fetched instruction word.
REQ-007 pc_in  input  PC_WIDTH  address of instr_in.
REQ-008 in_ready  output  1  buffer can accept an instruction this cycle.
REQ-009 flush  input  1  discard all buffered entries (branch or jump redirect).
REQ-010 out_valid  output  1  head entry valid for the decode stage.
REQ-011 out_ready  input  1  decode stage consumes the head entry.
REQ-012 instr_out  output  32  head instruction word.
REQ-013 pc_plus4_out  output  PC_WIDTH  head PC + 4.
REQ-014 opcode_out  output  6  bits [31:26] of instr_out.
REQ-015 rs_out, rt_out, rd_out  output  5 each  bits [25:21], [20:16] and [15:11] of instr_out.
REQ-016 imm16_out  output  16  bits [15:0] of instr_out; this is the data_in of the downstream 16-to-32 sign-extension stage.
REQ-017 count  output  2  current occupancy, 0 to 2.

Function
- REQ-018 Storage: two-entry FIFO (skid buffer); each entry holds {instr, pc+4}.
- REQ-019 in_ready shall equal (count < 2).
  - in_ready is derived from registered state only.
  - There is no combinational path from out_ready to in_ready.
- REQ-020 Push when in_valid && in_ready && !flush.
  - pc+4 is computed at push, modulo 2^PC_WIDTH.
  - pc_in = 0xFFFFFFFC stores 0x00000000.
- REQ-021 out_valid shall equal (count != 0).
  - Pop when out_valid && out_ready && !flush.
- REQ-022 Latency: an entry pushed in cycle N appears on the outputs with out_valid=1 in cycle N+1 at the earliest; no combinational bypass from input to output.
- REQ-023 Outputs (instr_out, pc_plus4_out and all decoded fields) shall be driven from the head entry while count != 0.
- REQ-024 When count == 0:
  - instr_out = NOP_INSTR;
  - pc_plus4_out = 0;
  - the decoded fields follow NOP_INSTR.
- REQ-025 Simultaneous push and pop with count == 1: count stays 1, the new entry becomes the head, and order is preserved.
- REQ-026 Simultaneous push and pop with count == 0: only the push is legal, so count becomes 1.
- REQ-027 With count == 2, in_ready = 0.
  - A pop that cycle yields count = 1.
  - in_valid is ignored and the fetch stage holds its data.
- REQ-028 Flush has priority over push and pop in the same cycle.
  - Next cycle: count = 0, out_valid = 0, all entries invalidated.
- REQ-029 Entries leave strictly in arrival order.
  - Read and write pointers wrap modulo 2.
  - No entry is duplicated or dropped except by flush.
- REQ-030 While out_valid = 1 and out_ready = 0, all outputs shall hold stable.

Reset
- REQ-031 Asserting rst shall, without waiting for a clock edge:
  - set count = 0, in_ready = 1, out_valid = 0;
  - set instr_out = NOP_INSTR, pc_plus4_out = 0;
  - reset both pointers to 0.
- REQ-032 Reset asserted mid-operation discards all buffered entries.
  - On the first rising edge after rst deasserts, normal push/pop behaviour applies.

Verification
- REQ-033 Single pass: push instr 0x2008FFFF, pc 0x00400000, out_ready = 1 -> next cycle:
  - out_valid = 1, pc_plus4_out = 0x00400004;
  - opcode_out = 6'h08, rs_out = 0, rt_out = 8, imm16_out = 16'hFFFF.
- REQ-034 Backpressure: out_ready = 0, push A then B -> count = 2, in_ready = 0, instr_out = A held stable; raise out_ready -> A then B delivered on consecutive cycles.
- REQ-035 Streaming: in_valid = 1 and out_ready = 1 continuously for 100 cycles -> count stays 1, throughput of one instruction per cycle, order preserved.
- REQ-036 Flush: count = 2, assert flush together with in_valid = 1 -> next cycle count = 0, out_valid = 0, instr_out = NOP_INSTR, incoming instruction dropped.
- REQ-037 Wrap: push pc_in = 0xFFFFFFFC -> pc_plus4_out = 0x00000000.
- REQ-038 Async reset: assert rst between clock edges with count = 2 -> out_valid = 0 and count = 0 immediately, before the next edge.
